// File: rtl/logic_proc_pkg.sv
// -----------------------------------------------------------------------------
// logic_proc_pkg
// Shared definitions for the lab 2.2 logic processor: the control FSM state
// encoding and the default register width. The downstream register unit uses
// the same width constant.
// -----------------------------------------------------------------------------
package logic_proc_pkg;

   // Two bits leave one unused encoding (2'b11); the FSM maps it back to IDLE.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      HOLD  = 2'b10
   } ctrl_state_t;

   localparam int DEFAULT_N_BITS = 4;

endpackage : logic_proc_pkg

// File: rtl/shift_control.sv
// -----------------------------------------------------------------------------
// shift_control
// Control FSM in front of the dual shift-register unit. It turns operator
// requests into load and shift strobes, runs exactly N_BITS shift cycles per
// Execute press, and waits for Execute to be released before accepting
// another operation.
//
// Ports
//   Clk        in   system clock, rising edge
//   Reset      in   asynchronous, active-high reset
//   LoadA      in   load request for register A (synchronous, debounced)
//   LoadB      in   load request for register B (synchronous, debounced)
//   Execute    in   operation start, level sensitive (synchronous, debounced)
//   Ld_A       out  load strobe to register A (combinational)
//   Ld_B       out  load strobe to register B (combinational)
//   Shift_En   out  shift strobe to both registers
//   Busy       out  high whenever the FSM is not idle
//   Done       out  one-cycle pulse on the first cycle after the final shift
//   Shift_Cnt  out  shifts completed in the current operation
// -----------------------------------------------------------------------------
module shift_control
   import logic_proc_pkg::*;
#(
   parameter int N_BITS = DEFAULT_N_BITS
) (
   input  logic                         Clk,
   input  logic                         Reset,
   input  logic                         LoadA,
   input  logic                         LoadB,
   input  logic                         Execute,
   output logic                         Ld_A,
   output logic                         Ld_B,
   output logic                         Shift_En,
   output logic                         Busy,
   output logic                         Done,
   output logic [$clog2(N_BITS+1)-1:0]  Shift_Cnt
);

   localparam int CNT_W = $clog2(N_BITS + 1);

   // Count value seen on the edge that completes the final shift.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BITS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   ctrl_state_t        state_q, state_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic               done_q,  done_d;

   // State, counter and Done pulse registers.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   // Next-state and counter logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (Execute) begin
               state_d = SHIFT;
               cnt_d   = '0;
            end
         end

         SHIFT: begin
            cnt_d = cnt_q + CNT_ONE;
            // The final shift happens in this cycle; Done is registered so it
            // appears on the first HOLD cycle only.
            if (cnt_q == CNT_LAST) begin
               state_d = HOLD;
               done_d  = 1'b1;
            end
         end

         HOLD: begin
            // Wait for Execute release so one press is one operation.
            if (!Execute) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Moore outputs from state; the load strobes also look at the live inputs
   // so a load lands on the same edge the request is seen. Execute wins over
   // a simultaneous load, and Reset blocks loads while it is asserted.
   always_comb begin
      Shift_En = (state_q == SHIFT);
      Busy     = (state_q != IDLE);
      Ld_A     = (state_q == IDLE) & LoadA & ~Execute & ~Reset;
      Ld_B     = (state_q == IDLE) & LoadB & ~Execute & ~Reset;
   end

   assign Done      = done_q;
   assign Shift_Cnt = cnt_q;

endmodule : shift_control

// File: tb/tb_shift_control.sv
// -----------------------------------------------------------------------------
// tb_shift_control
// Directed bench for shift_control. Three instances (N_BITS = 4, 1, 8) share
// one set of inputs; the N_BITS=4 instance is the main subject and the other
// two are examined in the parameter sweep.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_shift_control;

   logic Clk, Reset, LoadA, LoadB, Execute;

   logic       ld_a4, ld_b4, sh4, busy4, done4;
   logic [2:0] cnt4;
   logic       ld_a1, ld_b1, sh1, busy1, done1;
   logic [0:0] cnt1;
   logic       ld_a8, ld_b8, sh8, busy8, done8;
   logic [3:0] cnt8;

   int checks = 0;
   int errors = 0;

   shift_control #(.N_BITS(4)) dut4 (
      .Clk(Clk), .Reset(Reset), .LoadA(LoadA), .LoadB(LoadB), .Execute(Execute),
      .Ld_A(ld_a4), .Ld_B(ld_b4), .Shift_En(sh4), .Busy(busy4), .Done(done4),
      .Shift_Cnt(cnt4)
   );

   shift_control #(.N_BITS(1)) dut1 (
      .Clk(Clk), .Reset(Reset), .LoadA(LoadA), .LoadB(LoadB), .Execute(Execute),
      .Ld_A(ld_a1), .Ld_B(ld_b1), .Shift_En(sh1), .Busy(busy1), .Done(done1),
      .Shift_Cnt(cnt1)
   );

   shift_control #(.N_BITS(8)) dut8 (
      .Clk(Clk), .Reset(Reset), .LoadA(LoadA), .LoadB(LoadB), .Execute(Execute),
      .Ld_A(ld_a8), .Ld_B(ld_b8), .Shift_En(sh8), .Busy(busy8), .Done(done8),
      .Shift_Cnt(cnt8)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Advance to 1 ns after the next rising edge.
   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b1; Execute = 1'b1; LoadA = 1'b0; LoadB = 1'b0;
      cyc(); cyc();
      checks++;
      if ({ld_a4, ld_b4, sh4, busy4, done4} !== 5'b0) begin
         errors++;
         $display("FAIL reset_outputs got %b want 00000", {ld_a4, ld_b4, sh4, busy4, done4});
      end
      checks++;
      if (cnt4 !== 3'd0) begin
         errors++;
         $display("FAIL reset_cnt got %0d want 0", cnt4);
      end
      // Load requests during reset must not strobe even without Execute.
      Execute = 1'b0; LoadA = 1'b1; LoadB = 1'b1; #1;
      checks++;
      if ({ld_a4, ld_b4} !== 2'b00) begin
         errors++;
         $display("FAIL reset_load_gate got %b want 00", {ld_a4, ld_b4});
      end
      LoadA = 1'b0; LoadB = 1'b0; Execute = 1'b1; #1;
      Reset = 1'b0; #1;
      checks++;
      if (busy4 !== 1'b0 || sh4 !== 1'b0) begin
         errors++;
         $display("FAIL reset_release got busy=%b sh=%b want 0 0", busy4, sh4);
      end
      Execute = 1'b0;
      cyc();
      checks++;
      if (busy4 !== 1'b0) begin
         errors++;
         $display("FAIL reset_stay_idle got busy=%b want 0", busy4);
      end
   endtask

   task automatic test_basic();
      int shifts = 0;
      int dones  = 0;
      Execute = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         cyc();
         shifts += int'(sh4);
         dones  += int'(done4);
         checks++;
         if (sh4 !== (i <= 4) || done4 !== (i == 5) || busy4 !== 1'b1 ||
             cnt4 !== ((i <= 4) ? 3'(i - 1) : 3'd4)) begin
            errors++;
            $display("FAIL basic_cycle%0d got sh=%b done=%b busy=%b cnt=%0d", i, sh4, done4, busy4, cnt4);
         end
      end
      checks++;
      if (shifts != 4 || dones != 1) begin
         errors++;
         $display("FAIL basic_totals got shifts=%0d dones=%0d want 4 1", shifts, dones);
      end
      Execute = 1'b0;
      cyc();
      checks++;
      if (busy4 !== 1'b0 || cnt4 !== 3'd4) begin
         errors++;
         $display("FAIL basic_release got busy=%b cnt=%0d want 0 4", busy4, cnt4);
      end
   endtask

   task automatic test_short_press();
      Execute = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         cyc();
         if (i == 1) Execute = 1'b0;
         checks++;
         if (sh4 !== (i <= 4) || done4 !== (i == 5) || busy4 !== (i <= 5)) begin
            errors++;
            $display("FAIL short_cycle%0d got sh=%b done=%b busy=%b", i, sh4, done4, busy4);
         end
      end
   endtask

   task automatic test_loads();
      LoadA = 1'b1; LoadB = 1'b0; Execute = 1'b0; #1;
      checks++;
      if ({ld_a4, ld_b4} !== 2'b10) begin
         errors++;
         $display("FAIL load_a_only got %b want 10", {ld_a4, ld_b4});
      end
      LoadB = 1'b1; #1;
      checks++;
      if ({ld_a4, ld_b4} !== 2'b11) begin
         errors++;
         $display("FAIL load_both got %b want 11", {ld_a4, ld_b4});
      end
      Execute = 1'b1; #1;
      checks++;
      if ({ld_a4, ld_b4} !== 2'b00) begin
         errors++;
         $display("FAIL load_exec_prio got %b want 00", {ld_a4, ld_b4});
      end
      cyc();
      Execute = 1'b0; #1;
      checks++;
      if (sh4 !== 1'b1 || {ld_a4, ld_b4} !== 2'b00) begin
         errors++;
         $display("FAIL load_in_shift got sh=%b ld=%b want 1 00", sh4, {ld_a4, ld_b4});
      end
      // Remaining SHIFT cycles then HOLD: loads stay blocked throughout.
      for (int i = 2; i <= 5; i++) begin
         cyc();
         checks++;
         if ({ld_a4, ld_b4} !== 2'b00 || busy4 !== 1'b1) begin
            errors++;
            $display("FAIL load_blocked_cycle%0d got ld=%b busy=%b", i, {ld_a4, ld_b4}, busy4);
         end
      end
      cyc();
      checks++;
      if (busy4 !== 1'b0 || {ld_a4, ld_b4} !== 2'b11) begin
         errors++;
         $display("FAIL load_after_idle got busy=%b ld=%b want 0 11", busy4, {ld_a4, ld_b4});
      end
      LoadA = 1'b0; LoadB = 1'b0;
      cyc();
   endtask

   task automatic test_reset_mid();
      int shifts = 0;
      Execute = 1'b1;
      cyc();
      Execute = 1'b0;
      cyc();
      checks++;
      if (sh4 !== 1'b1 || cnt4 !== 3'd1) begin
         errors++;
         $display("FAIL mid_before got sh=%b cnt=%0d want 1 1", sh4, cnt4);
      end
      #2 Reset = 1'b1;
      #1;
      checks++;
      if (sh4 !== 1'b0 || busy4 !== 1'b0 || cnt4 !== 3'd0) begin
         errors++;
         $display("FAIL mid_async got sh=%b busy=%b cnt=%0d want 0 0 0", sh4, busy4, cnt4);
      end
      cyc();
      Reset = 1'b0;
      cyc();
      cyc();
      checks++;
      if (busy4 !== 1'b0 || sh4 !== 1'b0) begin
         errors++;
         $display("FAIL mid_no_resume got busy=%b sh=%b want 0 0", busy4, sh4);
      end
      Execute = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         cyc();
         if (i == 1) Execute = 1'b0;
         shifts += int'(sh4);
         checks++;
         if (sh4 !== (i <= 4) || cnt4 !== ((i <= 4) ? 3'(i - 1) : 3'd4) || done4 !== (i == 5)) begin
            errors++;
            $display("FAIL mid_rerun_cycle%0d got sh=%b cnt=%0d done=%b", i, sh4, cnt4, done4);
         end
      end
      checks++;
      if (shifts != 4 || busy4 !== 1'b0) begin
         errors++;
         $display("FAIL mid_rerun_total got shifts=%0d busy=%b want 4 0", shifts, busy4);
      end
   endtask

   task automatic test_sweep();
      int sh1_n = 0, sh8_n = 0, dn1_n = 0, dn8_n = 0;
      Reset = 1'b1;
      cyc();
      Reset = 1'b0;
      Execute = 1'b1;
      cyc();
      Execute = 1'b0;
      checks++;
      if (sh1 !== 1'b1 || cnt1 !== 1'b0) begin
         errors++;
         $display("FAIL n1_first got sh=%b cnt=%0d want 1 0", sh1, cnt1);
      end
      sh1_n += int'(sh1); sh8_n += int'(sh8);
      dn1_n += int'(done1); dn8_n += int'(done8);
      cyc();
      checks++;
      if (sh1 !== 1'b0 || done1 !== 1'b1 || cnt1 !== 1'b1) begin
         errors++;
         $display("FAIL n1_hold got sh=%b done=%b cnt=%0d want 0 1 1", sh1, done1, cnt1);
      end
      sh1_n += int'(sh1); sh8_n += int'(sh8);
      dn1_n += int'(done1); dn8_n += int'(done8);
      for (int i = 3; i <= 12; i++) begin
         cyc();
         sh1_n += int'(sh1); sh8_n += int'(sh8);
         dn1_n += int'(done1); dn8_n += int'(done8);
      end
      checks++;
      if (sh1_n != 1 || dn1_n != 1 || cnt1 !== 1'b1 || busy1 !== 1'b0) begin
         errors++;
         $display("FAIL n1_totals got sh=%0d done=%0d cnt=%0d busy=%b want 1 1 1 0", sh1_n, dn1_n, cnt1, busy1);
      end
      checks++;
      if (sh8_n != 8 || dn8_n != 1 || cnt8 !== 4'd8 || busy8 !== 1'b0) begin
         errors++;
         $display("FAIL n8_totals got sh=%0d done=%0d cnt=%0d busy=%b want 8 1 8 0", sh8_n, dn8_n, cnt8, busy8);
      end
   endtask

   initial begin
      Reset = 1'b1; LoadA = 1'b0; LoadB = 1'b0; Execute = 1'b0;
      test_reset();
      test_basic();
      test_short_press();
      test_loads();
      test_reset_mid();
      test_sweep();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_shift_control
